ifetch: RTL and testbench

Instruction-fetch initiator at the front of the pipeline. It owns the PC, issues instruction-bus requests, captures returned instruction words, and presents `{pc, raw_instr}` to the fetch/decode stage. It honours the downstream `stall`, and handles branch/jump redirects arriving at any point of an in-flight bus transaction.

---
 rtl/ifetch.sv | 109 ++++++++++
 tb/tb_ifetch.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction-fetch initiator: owns the PC, runs one bus transaction at a time,
// and presents the fetched {pc, instr} pair to decode under stall/redirect control.
module ifetch #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DROP
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pend_pc;
  logic [ILEN-1:0]   instr_q;

  // Address acceptance carries no information for a single-outstanding initiator.
  logic unused_addr_ok;
  assign unused_addr_ok = iresp_addr_ok;

  // Address and presented word come straight from state registers.
  assign ireq_addr = pc;
  assign out_pc    = pc;
  assign out_instr = instr_q;

  // Fetch FSM; the valid flags are registered alongside the state they decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      pend_pc    <= '0;
      instr_q    <= '0;
      ireq_valid <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state      <= REQ;
          ireq_valid <= 1'b1;
        end

        REQ: begin
          if (iresp_data_ok && redirect_valid) begin
            pc <= redirect_pc;
          end else if (iresp_data_ok) begin
            instr_q    <= iresp_data;
            state      <= HOLD;
            ireq_valid <= 1'b0;
            out_valid  <= 1'b1;
          end else if (redirect_valid) begin
            // Request must stay on the bus; remember where to go once it drains.
            pend_pc <= redirect_pc;
            state   <= DROP;
          end
        end

        DROP: begin
          if (iresp_data_ok) begin
            pc    <= redirect_valid ? redirect_pc : pend_pc;
            state <= REQ;
          end else if (redirect_valid) begin
            pend_pc <= redirect_pc;
          end
        end

        HOLD: begin
          if (redirect_valid) begin
            pc         <= redirect_pc;
            state      <= REQ;
            ireq_valid <= 1'b1;
            out_valid  <= 1'b0;
          end else if (!stall) begin
            pc         <= pc + PC_STEP;
            state      <= REQ;
            ireq_valid <= 1'b1;
            out_valid  <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          ireq_valid <= 1'b0;
          out_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: a bus responder and an output monitor check
// against expectation queues filled by the directed stimulus process.
module tb_ifetch;

  localparam logic [63:0] RPC = 64'h8000_0000;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  int checks   = 0;
  int failures = 0;
  int lat      = 2;

  logic [63:0] exp_req_q[$];
  logic [95:0] exp_out_q[$];

  ifetch #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_addr_ok  (iresp_addr_ok),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents seen by the bus: 0x8000_0000 holds 0x13, counting up by address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] - 32'h8000_0000 + 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: condition not seen within cycle budget", name);
  endtask

  task automatic push_req(input logic [63:0] a);
    exp_req_q.push_back(a);
  endtask

  task automatic push_out(input logic [63:0] a, input logic [31:0] d);
    exp_out_q.push_back({a, d});
  endtask

  task automatic pulse_redirect(input logic [63:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
  endtask

  task automatic wait_req(input logic [63:0] a);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (ireq_valid && ireq_addr == a) ok = 1'b1;
    end
    if (ok) checks++;
    else timeout_fail("wait_req");
  endtask

  task automatic wait_out();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    if (ok) checks++;
    else timeout_fail("wait_out");
  endtask

  task automatic wait_data_ok(input logic [63:0] a);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (iresp_data_ok && ireq_addr == a) ok = 1'b1;
    end
    if (ok) checks++;
    else timeout_fail("wait_data_ok");
  endtask

  // Bus responder: one transaction at a time, data_ok `lat` cycles after it starts.
  initial begin : responder
    bit          busy = 1'b0;
    int          rem  = 0;
    logic [63:0] cur  = '0;
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b0;
    iresp_data    = '0;
    forever begin
      @(posedge clk);
      #1;
      iresp_addr_ok = 1'b0;
      iresp_data_ok = 1'b0;
      if (reset) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          check("req_held", {ireq_valid, ireq_addr}, {1'b1, cur});
        end else if (ireq_valid) begin
          busy          = 1'b1;
          cur           = ireq_addr;
          rem           = lat;
          iresp_addr_ok = 1'b1;
          if (exp_req_q.size() == 0) begin
            timeout_fail("unexpected_req");
            $display("FAIL unexpected_req: addr %h", ireq_addr);
          end else begin
            check("req_addr", ireq_addr, exp_req_q.pop_front());
          end
        end
        if (busy) begin
          if (rem == 0) begin
            iresp_data_ok = 1'b1;
            iresp_data    = mem_word(cur);
            busy          = 1'b0;
          end else begin
            rem--;
          end
        end
      end
    end
  end

  // Output monitor: new presentations pop the scoreboard, held ones must not move.
  initial begin : monitor
    bit          prev_ov    = 1'b0;
    logic [63:0] prev_pc    = '0;
    logic [31:0] prev_instr = '0;
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        if (!prev_ov) begin
          if (exp_out_q.size() == 0) begin
            timeout_fail("unexpected_out");
            $display("FAIL unexpected_out: pc %h instr %h", out_pc, out_instr);
          end else begin
            check("out_pair", {out_pc, out_instr}, exp_out_q.pop_front());
          end
        end else begin
          check("out_stable", {out_pc, out_instr}, {prev_pc, prev_instr});
        end
        check("no_req_in_hold", ireq_valid, 1'b0);
      end
      prev_ov    = out_valid && !reset;
      prev_pc    = out_pc;
      prev_instr = out_instr;
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    lat            = 2;

    // Reset and first fetch.
    push_req(64'h8000_0000);
    push_out(64'h8000_0000, 32'h0000_0013);
    push_req(64'h8000_0004);
    push_out(64'h8000_0004, 32'h0000_0017);
    repeat (3) @(negedge clk);
    check("rst_ireq_valid", ireq_valid, 1'b0);
    check("rst_out_valid",  out_valid,  1'b0);
    check("rst_ireq_addr",  ireq_addr,  RPC);
    check("rst_out_pc",     out_pc,     RPC);
    check("rst_out_instr",  out_instr,  32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("first_req", {ireq_valid, ireq_addr}, {1'b1, RPC});

    // Stall hold for four cycles, then consume.
    wait_req(64'h8000_0004);
    stall = 1'b1;
    lat   = 3;
    wait_out();
    push_req(64'h8000_0008);
    repeat (4) @(negedge clk);
    stall = 1'b0;
    @(negedge clk);
    check("req_after_stall", {ireq_valid, ireq_addr}, {1'b1, 64'h8000_0008});

    // Redirect while 0x8000_0008 is still waiting for data.
    push_req(64'h8000_1000);
    push_out(64'h8000_1000, 32'h0000_1013);
    pulse_redirect(64'h8000_1000);
    lat = 1;

    // Redirect in the same cycle as data_ok.
    push_req(64'h8000_1004);
    push_req(64'h8000_2000);
    push_out(64'h8000_2000, 32'h0000_2013);
    wait_data_ok(64'h8000_1004);
    pulse_redirect(64'h8000_2000);
    stall = 1'b1;
    lat   = 4;

    // Redirect during a stalled HOLD wins over the stall.
    push_req(64'h8000_2800);
    wait_out();
    pulse_redirect(64'h8000_2800);
    stall = 1'b0;
    @(negedge clk);
    check("hold_redirect_req", {out_valid, ireq_valid, ireq_addr}, {1'b0, 1'b1, 64'h8000_2800});

    // Two redirects while draining; the later one is the one fetched.
    push_req(64'h8000_4000);
    pulse_redirect(64'h8000_3000);
    @(negedge clk);
    pulse_redirect(64'h8000_4000);
    wait_req(64'h8000_4000);

    // Asynchronous reset in the middle of a request.
    push_req(RPC);
    push_out(RPC, 32'h0000_0013);
    #2;
    reset = 1'b1;
    stall = 1'b1;
    lat   = 2;
    #1;
    check("async_rst_ireq_valid", ireq_valid, 1'b0);
    check("async_rst_out_valid",  out_valid,  1'b0);
    check("async_rst_addr",       ireq_addr,  RPC);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("restart_req", {ireq_valid, ireq_addr}, {1'b1, RPC});

    // PC wrap at the top of the address space.
    push_req(64'hFFFF_FFFF_FFFF_FFFC);
    push_out(64'hFFFF_FFFF_FFFF_FFFC, 32'h8000_000F);
    push_req(64'h0);
    push_out(64'h0, 32'h8000_0013);
    wait_out();
    pulse_redirect(64'hFFFF_FFFF_FFFF_FFFC);
    stall = 1'b0;
    wait_out();
    wait_req(64'h0);
    stall = 1'b1;
    wait_out();
    repeat (3) @(negedge clk);

    check("req_queue_drained", 96'(exp_req_q.size()), 96'd0);
    check("out_queue_drained", 96'(exp_out_q.size()), 96'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
